frequency_analysis_sequencer: RTL and testbench
===============================================

FREQUENCY_ANALYSIS_SEQUENCER -- requirements
Module: frequency_analysis_sequencer

Interface
REQ-001 Parameter RESULTS_NUMBER, default 6: result words dumped per window; legal range 1..7.
REQ-002 Parameter CLEAR_CYCLES, default 4: analyzer clear pulse length in clocks; legal range 1..255.
REQ-003 Parameter REGISTER_BASE, default 1: register number of the first result word; REGISTER_BASE+RESULTS_NUMBER-1 SHALL be <= 255.
REQ-004 clock  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begins a measurement when sampled high in IDLE.
REQ-007 abort  in  1  cancels a clear or measure phase.
REQ-008 continuous  in  1  re-arms automatically after each dump.
REQ-009 window_cycles  in  32  measurement window length in clocks, latched at start.
REQ-010 result_data  in  32  analyzer word selected by result_index, valid in the same cycle.
REQ-011 analyzer_clear  out  1  clear to all analyzers.
REQ-012 analyzer_enable  out  1  enable to all analyzers.
REQ-013 result_index  out  3  result select, 0-based.
REQ-014 register_operation  out  2  2 = write, 0 = idle.
REQ-015 register_number  out  8  target register of the write.
REQ-016 register_write  out  32  write data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 irq  out  1  one-clock pulse when a dump completes.

Function
REQ-019 FSM states: IDLE, CLEAR, MEASURE, DUMP, DONE; all outputs SHALL be registered.
REQ-020 IDLE: start=1 and window_cycles!=0 -> latch window_cycles, go to CLEAR; start with window_cycles=0 SHALL be ignored.
REQ-021 CLEAR: analyzer_clear=1 for exactly CLEAR_CYCLES consecutive clocks, then MEASURE.
REQ-022 MEASURE: analyzer_enable=1 for exactly the latched W clocks; a 32-bit down-counter with no wrap; then DUMP.
REQ-023 analyzer_clear and analyzer_enable SHALL never be high in the same cycle.
REQ-024 DUMP: result_index steps 0..RESULTS_NUMBER-1, one value per clock.
REQ-025 Write k SHALL appear one clock after result_index=k: register_operation=2, register_number=REGISTER_BASE+k, register_write=result_data sampled at index k.
REQ-026 Writes SHALL occur on consecutive clocks; each strobe lasts one clock; register_operation, register_number and register_write SHALL be 0 outside write cycles.
REQ-027 DONE: irq=1 for one clock, in the clock after the last write.
REQ-028 From DONE: continuous=1 -> CLEAR, using the still-latched W; continuous=0 -> IDLE.
REQ-029 abort=1 in CLEAR or MEASURE -> IDLE on the next clock; no writes and no irq are issued; analyzer_enable and analyzer_clear drop in that same transition.
REQ-030 abort in DUMP or DONE SHALL be ignored, so a dump always completes.
REQ-031 start while busy SHALL be ignored; window_cycles changes while busy SHALL have no effect.
REQ-032 abort and start high together in IDLE: abort wins and the block stays in IDLE.
REQ-033 abort and start high together in MEASURE: the block goes to IDLE and does not restart.
REQ-034 result_index SHALL hold 0 outside DUMP.

Reset
REQ-035 reset=1 at any clock edge, including mid-measure or mid-dump -> IDLE with every output 0, counters 0 and the latched window 0; no partial write or irq after reset.
REQ-036 reset SHALL take priority over start and abort.

Verification
REQ-037 Single run: window_cycles=10, start pulse, continuous=0 -> clear high 4 clocks, enable high 10 clocks, writes to registers 1..6 carrying the index-matched data on 6 consecutive clocks, then irq for 1 clock, busy=0.
REQ-038 Abort: window_cycles=100, abort at MEASURE clock 50 -> enable low next clock, IDLE, register_operation stays 0, no irq.
REQ-039 Continuous: window_cycles=3, continuous=1 for 3 runs -> 3 irq pulses; between runs the CLEAR phase restarts in the clock after irq; continuous=0 in run 3 -> IDLE.
REQ-040 Zero window: start with window_cycles=0 -> busy stays 0; start with window 1 -> enable high exactly 1 clock.
REQ-041 Reset mid-dump: reset after 3 writes -> all outputs 0 the next clock, no further writes, no irq.
REQ-042 Boundaries: RESULTS_NUMBER=7, REGISTER_BASE=249 -> register_number 249..255; abort during DUMP -> all 7 writes and irq still occur.

Source files
------------

// File: rtl/frequency_analysis_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frequency_analysis_sequencer                           |
// | Description : Sequences analyzer clear, timed measurement window and |
// |               register dump of the analyzer results, with abort and  |
// |               continuous re-arm. All outputs are registered.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frequency_analysis_sequencer #(
  parameter int RESULTS_NUMBER = 6,
  parameter int CLEAR_CYCLES   = 4,
  parameter int REGISTER_BASE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        continuous,
  input  logic [31:0] window_cycles,
  input  logic [31:0] result_data,
  output logic        analyzer_clear,
  output logic        analyzer_enable,
  output logic [2:0]  result_index,
  output logic [1:0]  register_operation,
  output logic [7:0]  register_number,
  output logic [31:0] register_write,
  output logic        busy,
  output logic        irq
);

  localparam logic [2:0]  c_idle       = 3'd0;
  localparam logic [2:0]  c_clear      = 3'd1;
  localparam logic [2:0]  c_measure    = 3'd2;
  localparam logic [2:0]  c_dump       = 3'd3;
  localparam logic [2:0]  c_done       = 3'd4;
  localparam logic [2:0]  c_results    = 3'(RESULTS_NUMBER);
  localparam logic [31:0] c_clear_load = 32'(CLEAR_CYCLES - 1);
  localparam logic [7:0]  c_reg_base   = 8'(REGISTER_BASE);
  localparam logic [1:0]  c_op_write   = 2'd2;

  logic [2:0]  r_state;
  logic [31:0] r_count;
  logic [2:0]  r_index;
  logic [31:0] r_window;

  logic [2:0]  w_state_next;
  logic [31:0] w_count_next;
  logic [2:0]  w_index_next;
  logic [31:0] w_window_next;

  logic        w_clear_next;
  logic        w_enable_next;
  logic [2:0]  w_result_index_next;
  logic        w_write_now;
  logic [1:0]  w_operation_next;
  logic [7:0]  w_number_next;
  logic [31:0] w_write_next;
  logic        w_busy_next;
  logic        w_irq_next;

  // State, phase counter, dump index and latched window registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= c_idle;
      r_count  <= '0;
      r_index  <= '0;
      r_window <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_index  <= w_index_next;
      r_window <= w_window_next;
    end
  end

  // Next-state logic; r_count holds the remaining clocks of the current phase minus one
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_index_next  = r_index;
    w_window_next = r_window;
    case (r_state)
      c_idle: begin
        if (!abort && start && (window_cycles != 32'd0)) begin
          w_window_next = window_cycles;
          w_state_next  = c_clear;
          w_count_next  = c_clear_load;
        end
      end
      c_clear: begin
        if (abort) begin
          w_state_next = c_idle;
          w_count_next = '0;
        end else if (r_count == 32'd0) begin
          w_state_next = c_measure;
          w_count_next = r_window - 32'd1;
        end else begin
          w_count_next = r_count - 32'd1;
        end
      end
      c_measure: begin
        if (abort) begin
          w_state_next = c_idle;
          w_count_next = '0;
        end else if (r_count == 32'd0) begin
          w_state_next = c_dump;
          w_index_next = '0;
        end else begin
          w_count_next = r_count - 32'd1;
        end
      end
      c_dump: begin
        // Index runs one past the last result so the final write can drain
        if (r_index == c_results) begin
          w_state_next = c_done;
          w_index_next = '0;
        end else begin
          w_index_next = r_index + 3'd1;
        end
      end
      c_done: begin
        if (continuous) begin
          w_state_next = c_clear;
          w_count_next = c_clear_load;
        end else begin
          w_state_next = c_idle;
        end
      end
      default: begin
        w_state_next = c_idle;
        w_count_next = '0;
        w_index_next = '0;
      end
    endcase
  end

  // Output decode from the upcoming state; writes capture the word selected this clock
  always_comb begin
    w_clear_next        = (w_state_next == c_clear);
    w_enable_next       = (w_state_next == c_measure);
    w_result_index_next = ((w_state_next == c_dump) && (w_index_next != c_results)) ? w_index_next : 3'd0;
    w_busy_next         = (w_state_next != c_idle);
    w_irq_next          = (w_state_next == c_done);
    w_write_now         = (r_state == c_dump) && (r_index != c_results);
    w_operation_next    = w_write_now ? c_op_write : 2'd0;
    w_number_next       = w_write_now ? (c_reg_base + {5'd0, r_index}) : 8'd0;
    w_write_next        = w_write_now ? result_data : 32'd0;
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      analyzer_clear     <= 1'b0;
      analyzer_enable    <= 1'b0;
      result_index       <= '0;
      register_operation <= '0;
      register_number    <= '0;
      register_write     <= '0;
      busy               <= 1'b0;
      irq                <= 1'b0;
    end else begin
      analyzer_clear     <= w_clear_next;
      analyzer_enable    <= w_enable_next;
      result_index       <= w_result_index_next;
      register_operation <= w_operation_next;
      register_number    <= w_number_next;
      register_write     <= w_write_next;
      busy               <= w_busy_next;
      irq                <= w_irq_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frequency_analysis_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_frequency_analysis_sequencer                        |
// | Description : Self-checking bench; two sequencer instances with      |
// |               different parameters share one stimulus stream and are |
// |               compared against a phase-offset reference model.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_frequency_analysis_sequencer;

  localparam int CC_A = 4, RN_A = 6, BASE_A = 1;
  localparam int CC_B = 3, RN_B = 7, BASE_B = 249;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] window_cycles = '0;
  logic [31:0] tbl [8];

  logic        clear_a, enable_a, busy_a, irq_a;
  logic [2:0]  index_a;
  logic [1:0]  op_a;
  logic [7:0]  num_a;
  logic [31:0] wr_a, data_a;
  logic        clear_b, enable_b, busy_b, irq_b;
  logic [2:0]  index_b;
  logic [1:0]  op_b;
  logic [7:0]  num_b;
  logic [31:0] wr_b, data_b;
  logic [48:0] obs_a, obs_b;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  // Analyzer model: word selected by the current index
  assign data_a = tbl[index_a];
  assign data_b = tbl[index_b];
  assign obs_a = {clear_a, enable_a, index_a, op_a, num_a, wr_a, busy_a, irq_a};
  assign obs_b = {clear_b, enable_b, index_b, op_b, num_b, wr_b, busy_b, irq_b};

  frequency_analysis_sequencer #(.RESULTS_NUMBER(RN_A), .CLEAR_CYCLES(CC_A), .REGISTER_BASE(BASE_A)) u_dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .window_cycles(window_cycles), .result_data(data_a),
    .analyzer_clear(clear_a), .analyzer_enable(enable_a), .result_index(index_a),
    .register_operation(op_a), .register_number(num_a), .register_write(wr_a),
    .busy(busy_a), .irq(irq_a));

  frequency_analysis_sequencer #(.RESULTS_NUMBER(RN_B), .CLEAR_CYCLES(CC_B), .REGISTER_BASE(BASE_B)) u_dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .window_cycles(window_cycles), .result_data(data_b),
    .analyzer_clear(clear_b), .analyzer_enable(enable_b), .result_index(index_b),
    .register_operation(op_b), .register_number(num_b), .register_write(wr_b),
    .busy(busy_b), .irq(irq_b));

  // Expected outputs in cycle j after the start edge (j=0 means idle)
  function automatic logic [48:0] exp_vec(input int j, input int w, input int cc, input int rn, input int base);
    logic        clr, en, bsy, irqv;
    logic [2:0]  idx;
    logic [1:0]  op;
    logic [7:0]  num;
    logic [31:0] dat;
    int d, wk;
    clr = 1'b0; en = 1'b0; bsy = 1'b0; irqv = 1'b0;
    idx = '0; op = '0; num = '0; dat = '0;
    if (j >= 1) begin
      clr  = (j <= cc);
      en   = (j > cc) && (j <= cc + w);
      d    = j - (cc + w + 1);
      if (d >= 0 && d < rn) idx = 3'(d);
      wk   = j - (cc + w + 2);
      if (wk >= 0 && wk < rn) begin
        op  = 2'd2;
        num = 8'(base + wk);
        dat = tbl[wk];
      end
      bsy  = (j <= cc + w + rn + 2);
      irqv = (j == cc + w + rn + 2);
    end
    return {clr, en, idx, op, num, dat, bsy, irqv};
  endfunction

  task automatic check(input string tag, input int j, input logic [48:0] obs, input logic [48:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, j, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 0, obs_a, exp_vec(0, 1, CC_A, RN_A, BASE_A));
    check({tag, "_b"}, 0, obs_b, exp_vec(0, 1, CC_B, RN_B, BASE_B));
  endtask

  // One measurement sequence of 'runs' back-to-back windows, optional abort/reset in run 1
  task automatic run_seq(input int w, input int runs, input int abort_at, input int reset_at, input bit noise);
    int j, run, len;
    bit ka, kb;
    for (int k = 0; k < 8; k++) tbl[k] = $urandom;
    len = w + CC_A + RN_A + 2;
    window_cycles = 32'(w);
    continuous = (runs > 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    j = 1; run = 1; ka = 1'b0; kb = 1'b0;
    while (run <= runs) begin
      check("run_a", j, obs_a, exp_vec(ka ? 0 : j, w, CC_A, RN_A, BASE_A));
      check("run_b", j, obs_b, exp_vec(kb ? 0 : j, w, CC_B, RN_B, BASE_B));
      continuous = (run < runs);
      abort = (run == 1) && (j == abort_at);
      reset = (run == 1) && (j == reset_at);
      start = abort;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        window_cycles = $urandom;
      end
      @(posedge clock); #1;
      if (run == 1 && j == reset_at) begin ka = 1'b1; kb = 1'b1; end
      if (run == 1 && j == abort_at && j <= CC_A + w) ka = 1'b1;
      if (run == 1 && j == abort_at && j <= CC_B + w) kb = 1'b1;
      abort = 1'b0; reset = 1'b0; start = 1'b0;
      j++;
      if (j > len) begin j = 1; run++; end
    end
    continuous = 1'b0;
    check_idle("after");
    @(posedge clock); #1;
    check_idle("after2");
  endtask

  initial begin
    int w;
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    // Reset has priority over start
    start = 1'b1; window_cycles = 32'd5;
    @(posedge clock); #1;
    check_idle("reset_start");
    reset = 1'b0;
    // Zero window is ignored
    window_cycles = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_idle("zero_win");
    // Abort beats start in IDLE
    window_cycles = 32'd5; abort = 1'b1;
    @(posedge clock); #1;
    check_idle("abort_idle");
    start = 1'b0; abort = 1'b0;
    @(posedge clock); #1;
    check_idle("abort_idle2");
    // Single run, window 10
    run_seq(10, 1, 0, 0, 1'b0);
    // Abort at measure clock 50 of a 100-clock window (start held with it)
    run_seq(100, 1, CC_A + 50, 0, 1'b0);
    // Continuous: three runs of window 3
    run_seq(3, 3, 0, 0, 1'b0);
    // Minimum window
    run_seq(1, 1, 0, 0, 1'b0);
    // Reset after the third write of instance A
    run_seq(6, 1, 0, CC_A + 6 + 4, 1'b0);
    // Abort during dump is ignored
    run_seq(5, 1, CC_A + 5 + 3, 0, 1'b0);
    // Abort on the last clear clock
    run_seq(4, 2, CC_B, 0, 1'b0);
    // Randomized windows, continuous counts and busy-time input noise
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 12);
      run_seq(w, $urandom_range(1, 3), 0, 0, 1'b1);
    end
    // Randomized abort points
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 12);
      run_seq(w, $urandom_range(1, 2), $urandom_range(1, w + CC_A + RN_A + 2), 0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
